// File: rtl/seg7_scan_arbiter_if.sv
// Request/data/display bundle shared between the two requesters and seg7_scan_arbiter.
// The master side drives requests and digit data; the slave (arbiter) drives grants and display lines.
interface seg7_scan_arbiter_if;
   logic        reqA;
   logic        reqB;
   logic [15:0] dataA;
   logic [15:0] dataB;
   logic        grantA;
   logic        grantB;
   logic [3:0]  bin4;
   logic [3:0]  seg7com;
   logic        frame_done;

   modport master (
      output reqA, reqB, dataA, dataB,
      input  grantA, grantB, bin4, seg7com, frame_done
   );

   modport slave (
      input  reqA, reqB, dataA, dataB,
      output grantA, grantB, bin4, seg7com, frame_done
   );
endinterface

// File: rtl/seg7_scan_arbiter.sv
// Four-digit multiplexed 7-segment scanner shared by two requesters, ownership decided per frame.
// Define SEG7_LZB_EN to blank leading-zero digits of the latched value.
module seg7_scan_arbiter #(
   parameter int unsigned SCAN_DIV    = 250000,
   parameter int unsigned GAP_CYC     = 16,
   parameter int unsigned HOLD_FRAMES = 64
) (
   input logic                CLK,
   input logic                RSTn,
   seg7_scan_arbiter_if.slave bus
);

   localparam int unsigned LIT_LEN = (SCAN_DIV == 0) ? 1 : SCAN_DIV;
   localparam int unsigned GAP_LEN = (GAP_CYC == 0) ? 1 : GAP_CYC;
   localparam int unsigned HOLD_W  = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(HOLD_FRAMES);

   typedef enum logic [1:0] {IDLE, LIT, GAP} state_t;

   state_t            state, state_nxt;
   logic [1:0]        digit_idx, idx_nxt;
   logic [31:0]       phase_cnt, cnt_nxt;
   logic [15:0]       frame_reg, frame_nxt;
   logic              grant_a, grant_a_nxt;
   logic              grant_b, grant_b_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic              frame_done_q, done_nxt;
   logic              take_a, take_b, keep_owner, go_idle;
   logic              owner_req, other_req, held_enough;
   logic [3:0]        seg_out, nib_out;

   // The current frame counts toward the hold, hence the +1.
   assign held_enough = (32'(hold_cnt) + 32'd1) >= HOLD_FRAMES;
   assign owner_req   = grant_a ? bus.reqA : bus.reqB;
   assign other_req   = grant_a ? bus.reqB : bus.reqA;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state        <= IDLE;
         digit_idx    <= 2'd0;
         phase_cnt    <= 32'd0;
         frame_reg    <= 16'h0;
         grant_a      <= 1'b0;
         grant_b      <= 1'b0;
         hold_cnt     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         digit_idx    <= idx_nxt;
         phase_cnt    <= cnt_nxt;
         frame_reg    <= frame_nxt;
         grant_a      <= grant_a_nxt;
         grant_b      <= grant_b_nxt;
         hold_cnt     <= hold_nxt;
         frame_done_q <= done_nxt;
      end
   end

   // Arbitration happens only on the IDLE exit and on the last GAP cycle of digit 3.
   always_comb begin
      state_nxt   = state;
      idx_nxt     = digit_idx;
      cnt_nxt     = phase_cnt;
      frame_nxt   = frame_reg;
      grant_a_nxt = grant_a;
      grant_b_nxt = grant_b;
      hold_nxt    = hold_cnt;
      done_nxt    = 1'b0;
      take_a      = 1'b0;
      take_b      = 1'b0;
      keep_owner  = 1'b0;
      go_idle     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.reqA)      take_a = 1'b1;
            else if (bus.reqB) take_b = 1'b1;
         end
         LIT: begin
            if (phase_cnt == LIT_LEN - 1) begin
               state_nxt = GAP;
               cnt_nxt   = 32'd0;
            end else begin
               cnt_nxt = phase_cnt + 32'd1;
            end
         end
         GAP: begin
            if (phase_cnt != GAP_LEN - 1) begin
               cnt_nxt = phase_cnt + 32'd1;
            end else if (digit_idx != 2'd3) begin
               state_nxt = LIT;
               idx_nxt   = digit_idx + 2'd1;
               cnt_nxt   = 32'd0;
            end else begin
               done_nxt = 1'b1;
               if (!owner_req && !other_req) begin
                  go_idle = 1'b1;
               end else if (!owner_req || held_enough && other_req) begin
                  take_a = grant_b;
                  take_b = grant_a;
               end else begin
                  keep_owner = 1'b1;
                  take_a     = grant_a;
                  take_b     = grant_b;
               end
            end
         end
         default: go_idle = 1'b1;
      endcase
      if (take_a || take_b) begin
         state_nxt   = LIT;
         idx_nxt     = 2'd0;
         cnt_nxt     = 32'd0;
         grant_a_nxt = take_a;
         grant_b_nxt = take_b;
         frame_nxt   = take_a ? bus.dataA : bus.dataB;
         if (keep_owner) hold_nxt = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + 1'b1;
         else            hold_nxt = '0;
      end
      if (go_idle) begin
         state_nxt   = IDLE;
         idx_nxt     = 2'd0;
         cnt_nxt     = 32'd0;
         grant_a_nxt = 1'b0;
         grant_b_nxt = 1'b0;
         hold_nxt    = '0;
      end
   end

`ifdef SEG7_LZB_EN
   logic [3:0] blank;

   // A digit is blank when it and every more significant nibble are zero; digit 0 always shows.
   always_comb begin
      blank[3] = (frame_reg[15:12] == 4'h0);
      blank[2] = blank[3] && (frame_reg[11:8] == 4'h0);
      blank[1] = blank[2] && (frame_reg[7:4] == 4'h0);
      blank[0] = 1'b0;
   end
`endif

   // Display lines are dark outside LIT so the external decoder never ghosts between digits.
   always_comb begin
      seg_out = 4'b1111;
      nib_out = 4'h0;
      if (state == LIT) begin
         nib_out = frame_reg[{digit_idx, 2'b00} +: 4];
         seg_out = ~(4'b0001 << digit_idx);
`ifdef SEG7_LZB_EN
         if (blank[digit_idx]) seg_out = 4'b1111;
`endif
      end
   end

   assign bus.grantA     = grant_a;
   assign bus.grantB     = grant_b;
   assign bus.bin4       = nib_out;
   assign bus.seg7com    = seg_out;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_arbiter.sv
// Scoreboard bench for seg7_scan_arbiter: stimulus queues expected display/frame events, a monitor
// reconstructs events from the outputs and compares. Honors SEG7_LZB_EN for expected blanking.
module tb_seg7_scan_arbiter;

   localparam int unsigned SD    = 4;
   localparam int unsigned GC    = 2;
   localparam int unsigned HF    = 2;
   localparam int          FRAME = 4 * (SD + GC);

   typedef enum logic [1:0] {EV_DIG, EV_FRAME, EV_PROBE} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic       gA;
      logic       gB;
      logic [3:0] seg;
      logic [3:0] bin;
      logic       fd;
      int         len;
      int         tag;
   } ev_t;

   logic CLK  = 1'b0;
   logic RSTn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   probeReq = 1'b0;
   ev_t  expQ[$];

   seg7_scan_arbiter_if bus();

   seg7_scan_arbiter #(.SCAN_DIV(SD), .GAP_CYC(GC), .HOLD_FRAMES(HF)) dut (
      .CLK (CLK),
      .RSTn(RSTn),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   function automatic ev_t mkEv(input ev_kind_t k, input logic a, input logic b, input logic [3:0] s,
                                input logic [3:0] n, input logic f, input int l, input int t);
      ev_t e;
      e.kind = k; e.gA = a; e.gB = b; e.seg = s; e.bin = n; e.fd = f; e.len = l; e.tag = t;
      return e;
   endfunction

   function automatic string kindName(input ev_kind_t k);
      case (k)
         EV_DIG:   return "digit";
         EV_FRAME: return "frame";
         default:  return "probe";
      endcase
   endfunction

   task automatic checkOutput(input ev_t act);
      ev_t e;
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL %s unexpected: got gA=%0b gB=%0b seg=%b bin=%h fd=%0b len=%0d, required no event",
                  kindName(act.kind), act.gA, act.gB, act.seg, act.bin, act.fd, act.len);
      end else begin
         e = expQ.pop_front();
         if (act.kind !== e.kind || act.gA !== e.gA || act.gB !== e.gB || act.seg !== e.seg ||
             act.bin !== e.bin || act.fd !== e.fd || act.len != e.len) begin
            errors++;
            $display("[TB] FAIL %s tag=%0d: got %s gA=%0b gB=%0b seg=%b bin=%h fd=%0b len=%0d, required %s gA=%0b gB=%0b seg=%b bin=%h fd=%0b len=%0d",
                     kindName(e.kind), e.tag, kindName(act.kind), act.gA, act.gB, act.seg, act.bin,
                     act.fd, act.len, kindName(e.kind), e.gA, e.gB, e.seg, e.bin, e.fd, e.len);
         end
      end
   endtask

   // Monitor: a digit event closes when the commons go dark, a frame event on every frame_done.
   initial begin : monitor
      bit         prevLit;
      bit         prevG;
      int         litLen;
      int         cyc;
      int         mark;
      logic [3:0] curSeg, curBin;
      logic       curA, curB;
      prevLit = 1'b0; prevG = 1'b0; litLen = 0; cyc = 0; mark = 0;
      curSeg = 4'h0; curBin = 4'h0; curA = 1'b0; curB = 1'b0;
      forever begin
         @(negedge CLK);
         cyc++;
         if (probeReq) begin
            probeReq = 1'b0;
            checkOutput(mkEv(EV_PROBE, bus.grantA, bus.grantB, bus.seg7com, bus.bin4, bus.frame_done, 0, 0));
         end
         if (!RSTn) begin
            prevLit = 1'b0;
            prevG   = 1'b0;
            litLen  = 0;
         end else begin
            if (bus.seg7com != 4'b1111) begin
               if (!prevLit) litLen = 0;
               litLen++;
               curSeg = bus.seg7com; curBin = bus.bin4; curA = bus.grantA; curB = bus.grantB;
               prevLit = 1'b1;
            end else if (prevLit) begin
               prevLit = 1'b0;
               checkOutput(mkEv(EV_DIG, curA, curB, curSeg, curBin, 1'b0, litLen, 0));
            end
            if ((bus.grantA | bus.grantB) && !prevG) mark = cyc;
            prevG = bus.grantA | bus.grantB;
            if (bus.frame_done) begin
               checkOutput(mkEv(EV_FRAME, bus.grantA, bus.grantB, 4'h0, 4'h0, 1'b1, cyc - mark, 0));
               mark = cyc;
            end
         end
      end
   end

   // Reset must darken the display and drop grants without any clock edge.
   initial begin : resetWatch
      forever begin
         @(negedge RSTn);
         #1;
         checks++;
         if (bus.seg7com !== 4'b1111 || bus.grantA !== 1'b0 || bus.grantB !== 1'b0 ||
             bus.bin4 !== 4'h0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got seg=%b bin=%h gA=%b gB=%b fd=%b, required seg=1111 bin=0 gA=0 gB=0 fd=0",
                     bus.seg7com, bus.bin4, bus.grantA, bus.grantB, bus.frame_done);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge CLK);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic ra, input logic rb, input logic [15:0] da, input logic [15:0] db);
      step(1);
      bus.reqA = ra; bus.reqB = rb; bus.dataA = da; bus.dataB = db;
   endtask

   task automatic pushProbe(input int tag, input logic a, input logic b, input logic [3:0] s, input logic [3:0] n);
      expQ.push_back(mkEv(EV_PROBE, a, b, s, n, 1'b0, 0, tag));
      probeReq = 1'b1;
   endtask

   task automatic pushDigits(input int tag, input logic a, input logic b, input logic [15:0] data, input int nDig);
      logic [3:0] s;
      for (int n = 0; n < nDig; n++) begin
         bit show;
         show = 1'b1;
`ifdef SEG7_LZB_EN
         if (n > 0 && (data >> (4 * n)) == 16'h0) show = 1'b0;
`endif
         s = ~(4'b0001 << n);
         if (show) expQ.push_back(mkEv(EV_DIG, a, b, s, data[4*n +: 4], 1'b0, SD, tag));
      end
   endtask

   task automatic pushFrameEnd(input int tag, input logic a, input logic b);
      expQ.push_back(mkEv(EV_FRAME, a, b, 4'h0, 4'h0, 1'b1, FRAME, tag));
   endtask

   task automatic waitSeg(input logic [3:0] v, input int budget);
      int n = 0;
      while (bus.seg7com !== v && n < budget) begin
         step(1);
         n++;
      end
      checks++;
      if (bus.seg7com !== v) begin
         errors++;
         $display("[TB] FAIL wait_seg: got seg=%b after %0d cycles, required seg=%b", bus.seg7com, n, v);
      end
   endtask

   task automatic waitFrame(input int budget);
      int n = 0;
      do begin
         step(1);
         n++;
      end while (bus.frame_done !== 1'b1 && n < budget);
      checks++;
      if (bus.frame_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wait_frame: got no frame_done in %0d cycles, required a pulse", n);
      end
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while (expQ.size() != 0 && n < budget) begin
         step(1);
         n++;
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending events, required 0", expQ.size());
         expQ.delete();
      end
   endtask

   initial begin : stimulus
      bus.reqA = 1'b0; bus.reqB = 1'b0; bus.dataA = 16'h0; bus.dataB = 16'h0;
      step(2);
      pushProbe(1, 1'b0, 1'b0, 4'b1111, 4'h0);
      step(1);
      RSTn = 1'b1;
      step(2);
      pushProbe(2, 1'b0, 1'b0, 4'b1111, 4'h0);
      step(1);

      // Single owner, two frames, drop mid digit 1 of the second frame.
      applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0);
      pushProbe(10, 1'b1, 1'b0, 4'b1110, 4'h4);
      pushDigits(11, 1'b1, 1'b0, 16'h1234, 4);
      pushFrameEnd(12, 1'b1, 1'b0);
      pushDigits(13, 1'b1, 1'b0, 16'h1234, 4);
      waitFrame(100);
      waitSeg(4'b1101, 100);
      bus.reqA = 1'b0;
      pushFrameEnd(14, 1'b0, 1'b0);
      waitDrain(100);
      step(3);
      pushProbe(15, 1'b0, 1'b0, 4'b1111, 4'h0);
      step(2);

      // Data change during digit 2 only shows up after the next latch.
      applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0);
      pushDigits(20, 1'b1, 1'b0, 16'h1234, 4);
      pushFrameEnd(21, 1'b1, 1'b0);
      pushDigits(22, 1'b1, 1'b0, 16'hABCD, 4);
      waitSeg(4'b1011, 100);
      bus.dataA = 16'hABCD;
      waitFrame(100);
      waitSeg(4'b1101, 100);
      bus.reqA = 1'b0;
      pushFrameEnd(23, 1'b0, 1'b0);
      waitDrain(100);
      step(3);

      // Simultaneous requests: A first, ownership alternates every two frames.
      applyStimulus(1'b1, 1'b1, 16'h3210, 16'h7654);
      pushProbe(30, 1'b1, 1'b0, 4'b1110, 4'h0);
      pushDigits(31, 1'b1, 1'b0, 16'h3210, 4);
      pushFrameEnd(31, 1'b1, 1'b0);
      pushDigits(32, 1'b1, 1'b0, 16'h3210, 4);
      pushFrameEnd(32, 1'b0, 1'b1);
      pushDigits(33, 1'b0, 1'b1, 16'h7654, 4);
      pushFrameEnd(33, 1'b0, 1'b1);
      pushDigits(34, 1'b0, 1'b1, 16'h7654, 4);
      pushFrameEnd(34, 1'b1, 1'b0);
      pushDigits(35, 1'b1, 1'b0, 16'h3210, 4);
      pushFrameEnd(35, 1'b0, 1'b0);
      repeat (4) waitFrame(100);
      waitSeg(4'b1101, 100);
      bus.reqA = 1'b0;
      bus.reqB = 1'b0;
      waitDrain(100);
      step(3);

      // B alone; B drops while A requests, so A takes over at the boundary.
      applyStimulus(1'b0, 1'b1, 16'h0, 16'h0F0E);
      pushDigits(40, 1'b0, 1'b1, 16'h0F0E, 4);
      pushFrameEnd(41, 1'b1, 1'b0);
      pushDigits(42, 1'b1, 1'b0, 16'h1234, 4);
      pushFrameEnd(43, 1'b0, 1'b0);
      step(3);
      bus.reqA = 1'b1; bus.dataA = 16'h1234; bus.reqB = 1'b0;
      waitFrame(100);
      step(3);
      bus.reqA = 1'b0;
      waitDrain(100);
      step(3);

      // Leading zeros: all digits lit by default, only digit 0 with blanking enabled.
      applyStimulus(1'b1, 1'b0, 16'h0005, 16'h0);
      pushDigits(50, 1'b1, 1'b0, 16'h0005, 4);
      pushFrameEnd(51, 1'b0, 1'b0);
      step(2);
      bus.reqA = 1'b0;
      waitDrain(100);
      step(3);

      // Asynchronous reset during digit 3, held with a pending request.
      applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0);
      pushDigits(60, 1'b1, 1'b0, 16'h1234, 3);
      waitSeg(4'b0111, 100);
      @(posedge CLK);
      #2;
      RSTn = 1'b0;
      step(1);
      waitDrain(10);
      pushProbe(61, 1'b0, 1'b0, 4'b1111, 4'h0);
      step(1);
      pushDigits(62, 1'b1, 1'b0, 16'h1234, 4);
      RSTn = 1'b1;
      waitSeg(4'b1101, 100);
      bus.reqA = 1'b0;
      pushFrameEnd(63, 1'b0, 1'b0);
      waitDrain(100);
      step(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_arbiter.md
SEG7_SCAN_ARBITER -- requirements
Module: seg7_scan_arbiter

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 250000, meaning CLK cycles each digit is lit.
REQ-002 The block SHALL have parameter GAP_CYC, default 16, meaning CLK cycles all digits are dark between digits (anti-ghosting).
REQ-003 The block SHALL have parameter HOLD_FRAMES, default 64, meaning minimum frames an owner keeps the display while the other requester waits.
REQ-004 The block SHALL have port CLK  input  1  clock, rising edge.
REQ-005 The block SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have ports reqA / reqB  input  1  display request from requester A / B, level.
REQ-007 The block SHALL have ports dataA / dataB  input  16  four hex digits from A / B; digit n is bits [4n+3:4n].
REQ-008 The block SHALL have ports grantA / grantB  output  1  ownership indication, one-hot or zero.
REQ-009 The block SHALL have port bin4  output  4  nibble for the external BIN4-to-7SEG decoder.
REQ-010 The block SHALL have port seg7com  output  4  digit commons, active-low, bit n = digit n.
REQ-011 The block SHALL have port frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 The FSM SHALL have states IDLE, LIT and GAP, plus a 2-bit digit index.
REQ-013 In IDLE, seg7com SHALL be 4'b1111, bin4 4'h0, and both grants 0.
REQ-014 From IDLE, a request SHALL grant on the next edge, with A winning a simultaneous request; the owner's data is latched into a 16-bit frame register, and the FSM enters LIT with digit 0.
REQ-015 In LIT, seg7com SHALL drive digit index low only and bin4 the latched nibble; after exactly SCAN_DIV cycles the FSM enters GAP.
REQ-016 In GAP, seg7com SHALL be 4'b1111 for exactly GAP_CYC cycles; the FSM then enters LIT with index+1, or performs a frame boundary if the index is 3.
REQ-017 At a frame boundary, frame_done SHALL pulse for one cycle, and ownership is re-evaluated on that same edge.
REQ-018 Owner drops req: ownership SHALL pass to the other requester if it is requesting, else the FSM goes to IDLE.
REQ-019 Both requesting and the owner has held at least HOLD_FRAMES frames: ownership SHALL switch (round-robin) and the frame counter clears.
REQ-020 Otherwise the owner SHALL be retained, the frame counter incremented (saturating), and the owner's data re-latched.
REQ-021 The grant SHALL change only at frame boundaries; a req drop mid-frame does not truncate the frame.
REQ-022 Data changes mid-frame SHALL NOT affect the display until the next latch.
REQ-023 A parameter value of 0 for SCAN_DIV or GAP_CYC SHALL be treated as 1.

Reset
REQ-024 Asserting RSTn low SHALL asynchronously force IDLE, grants 0, seg7com 4'b1111, bin4 0, frame_done 0, all counters and the frame register 0, including mid-frame.
REQ-025 After RSTn rises, the first grant SHALL occur no earlier than the first CLK edge with RSTn high.

Configuration
REQ-026 With macro SEG7_LZB_EN defined, leading-zero digits of the latched value SHALL be blanked: seg7com is 1 for digit n when all nibbles n..3 are 0 and n>0, with digit 0 always lit.
REQ-027 Without SEG7_LZB_EN, all four digits SHALL be lit in turn regardless of value.

Verification (SCAN_DIV=4, GAP_CYC=2, HOLD_FRAMES=2)
REQ-028 Scenario: reset, then reqA=1 with dataA=16'h1234 -> grantA=1 next edge; seg7com cycles 1110/1111/1101/1111/1011/1111/0111/1111 with bin4 4,3,2,1; each LIT lasts 4 cycles and each GAP 2; frame_done pulses every 24 cycles.
REQ-029 Scenario: reqA and reqB rise on the same cycle -> grantA; A keeps ownership for 2 frames, then grantB at the 2nd frame_done; the pattern alternates every 2 frames thereafter.
REQ-030 Scenario: reqA drops mid-digit-1 with reqB=0 -> the frame completes, then the FSM goes to IDLE with seg7com=1111 and grants 0.
REQ-031 Scenario: dataA changes from 16'h1234 to 16'hABCD during digit 2 -> the frame in progress shows 1234, and the next frame shows ABCD.
REQ-032 Scenario: RSTn pulsed low during LIT digit 3 -> seg7com=1111 and grants 0 immediately, without waiting for CLK.
REQ-033 Scenario: SEG7_LZB_EN defined and dataA=16'h0005 -> only digit 0 is lit with bin4=5, while digits 1-3 show seg7com bit 1 and frame timing is unchanged.
